// File: rtl/map_scroll_ctrl_pkg.sv
// rtl/map_scroll_ctrl_pkg.sv - shared constants and types for the map scroll controller
package map_scroll_pkg;

  localparam logic [1:0] DIR_DOWN  = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [3:0] STATE_MAIN_GAME = 4'd3;

  localparam int DEFAULT_TILE_PX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    MOVE = 2'd2
  } scroll_state_t;

endpackage

// File: rtl/map_scroll_ctrl_if.sv
// rtl/map_scroll_ctrl_if.sv - collision-map read port between controller and map memory
interface map_scroll_ctrl_if;

  logic        map_rd;
  logic [11:0] map_addr;
  logic        map_rdata;

  modport master (output map_rd, output map_addr, input map_rdata);
  modport slave  (input map_rd, input map_addr, output map_rdata);

endinterface

// File: rtl/map_scroll_ctrl_vsync_tick.sv
// rtl/map_scroll_ctrl_vsync_tick.sv - VGA vsync synchronizer and rising-edge frame pulse
module vsync_tick (
  input  logic clk,
  input  logic rst_n,
  input  logic vs_in,
  output logic tick
);

  logic s1_q, s2_q, s3_q;

  // two-flop synchronizer followed by one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= vs_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick = s2_q & ~s3_q;

endmodule

// File: rtl/map_scroll_ctrl.sv
// rtl/map_scroll_ctrl.sv - tile position tracking, collision check and per-frame camera scroll
module map_scroll_ctrl
  import map_scroll_pkg::*;
#(
  parameter int TILE_PX = DEFAULT_TILE_PX,
  parameter int MAP_W   = 64,
  parameter int MAP_H   = 64,
  parameter int START_X = 10,
  parameter int START_Y = 10,
  parameter int WALK_PX = 1,
  parameter int RUN_PX  = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                VGA_VS,
  input  logic [3:0]          state_num,
  input  logic                charIsMoving,
  input  logic                charIsRunning,
  input  logic [1:0]          direction,
  map_scroll_ctrl_if.master   mif,
  output logic [5:0]          tile_x,
  output logic [5:0]          tile_y,
  output logic [9:0]          scroll_x,
  output logic [9:0]          scroll_y,
  output logic                walking,
  output logic                step_done,
  output logic                bumped
);

  localparam int OFF_W = $clog2(TILE_PX) + 1;

  logic frame_tick;

  scroll_state_t     state_q, state_d;
  logic [5:0]        tile_x_q, tile_x_d, tile_y_q, tile_y_d;
  logic [OFF_W-1:0]  offset_q, offset_d, off_next;
  logic [1:0]        dir_q, dir_d, dsel;
  logic              run_q, run_d;
  logic              map_rd_q, map_rd_d;
  logic [11:0]       map_addr_q, map_addr_d;
  logic              step_done_q, step_done_d;
  logic              bumped_q, bumped_d;
  logic              walking_q, walking_d;
  logic [9:0]        scroll_x_q, scroll_x_d, scroll_y_q, scroll_y_d;
  logic [9:0]        base_x, base_y;
  logic [5:0]        tgt_x, tgt_y;
  logic              in_bounds;

  vsync_tick u_vsync_tick (
    .clk   (Clk),
    .rst_n (Reset),
    .vs_in (VGA_VS),
    .tick  (frame_tick)
  );

  // neighbour tile in the live direction while idle, in the latched one mid-step
  always_comb begin
    dsel      = (state_q == IDLE) ? direction : dir_q;
    tgt_x     = tile_x_q;
    tgt_y     = tile_y_q;
    in_bounds = 1'b1;
    case (dsel)
      DIR_DOWN:  if (int'(tile_y_q) >= MAP_H - 1) in_bounds = 1'b0; else tgt_y = tile_y_q + 6'd1;
      DIR_UP:    if (tile_y_q == 6'd0) in_bounds = 1'b0; else tgt_y = tile_y_q - 6'd1;
      DIR_LEFT:  if (tile_x_q == 6'd0) in_bounds = 1'b0; else tgt_x = tile_x_q - 6'd1;
      default:   if (int'(tile_x_q) >= MAP_W - 1) in_bounds = 1'b0; else tgt_x = tile_x_q + 6'd1;
    endcase
  end

  // step FSM: request the collision bit, wait for it, then glide one tile
  always_comb begin
    state_d     = state_q;
    tile_x_d    = tile_x_q;
    tile_y_d    = tile_y_q;
    offset_d    = offset_q;
    dir_d       = dir_q;
    run_d       = run_q;
    map_rd_d    = 1'b0;
    map_addr_d  = map_addr_q;
    step_done_d = 1'b0;
    bumped_d    = 1'b0;
    off_next    = offset_q + (run_q ? OFF_W'(RUN_PX) : OFF_W'(WALK_PX));
    case (state_q)
      IDLE: begin
        if (frame_tick && state_num == STATE_MAIN_GAME && charIsMoving) begin
          dir_d = direction;
          run_d = charIsRunning;
          if (!in_bounds) begin
            bumped_d = 1'b1;
          end else begin
            map_rd_d   = 1'b1;
            map_addr_d = 12'(int'(tgt_y) * MAP_W + int'(tgt_x));
            state_d    = RESP;
          end
        end
      end
      RESP: begin
        // first RESP cycle is the strobe cycle; rdata is valid on the second
        if (!map_rd_q) begin
          if (mif.map_rdata) begin
            bumped_d = 1'b1;
            state_d  = IDLE;
          end else begin
            offset_d = '0;
            state_d  = MOVE;
          end
        end
      end
      MOVE: begin
        if (frame_tick) begin
          if (state_num != STATE_MAIN_GAME) begin
            offset_d = '0;
            state_d  = IDLE;
          end else if (off_next >= OFF_W'(TILE_PX)) begin
            tile_x_d    = tgt_x;
            tile_y_d    = tgt_y;
            offset_d    = '0;
            step_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            offset_d = off_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // camera position follows the next tile/offset so it lands with them
  always_comb begin
    base_x     = 10'(int'(tile_x_d) * TILE_PX);
    base_y     = 10'(int'(tile_y_d) * TILE_PX);
    scroll_x_d = base_x;
    scroll_y_d = base_y;
    case (dir_d)
      DIR_RIGHT: scroll_x_d = base_x + 10'(offset_d);
      DIR_LEFT:  scroll_x_d = base_x - 10'(offset_d);
      DIR_DOWN:  scroll_y_d = base_y + 10'(offset_d);
      default:   scroll_y_d = base_y - 10'(offset_d);
    endcase
    walking_d = (state_d == MOVE);
  end

  // register all state and outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      tile_x_q    <= 6'(START_X);
      tile_y_q    <= 6'(START_Y);
      offset_q    <= '0;
      dir_q       <= DIR_DOWN;
      run_q       <= 1'b0;
      map_rd_q    <= 1'b0;
      map_addr_q  <= '0;
      step_done_q <= 1'b0;
      bumped_q    <= 1'b0;
      walking_q   <= 1'b0;
      scroll_x_q  <= 10'(START_X * TILE_PX);
      scroll_y_q  <= 10'(START_Y * TILE_PX);
    end else begin
      state_q     <= state_d;
      tile_x_q    <= tile_x_d;
      tile_y_q    <= tile_y_d;
      offset_q    <= offset_d;
      dir_q       <= dir_d;
      run_q       <= run_d;
      map_rd_q    <= map_rd_d;
      map_addr_q  <= map_addr_d;
      step_done_q <= step_done_d;
      bumped_q    <= bumped_d;
      walking_q   <= walking_d;
      scroll_x_q  <= scroll_x_d;
      scroll_y_q  <= scroll_y_d;
    end
  end

  assign mif.map_rd   = map_rd_q;
  assign mif.map_addr = map_addr_q;
  assign tile_x       = tile_x_q;
  assign tile_y       = tile_y_q;
  assign scroll_x     = scroll_x_q;
  assign scroll_y     = scroll_y_q;
  assign walking      = walking_q;
  assign step_done    = step_done_q;
  assign bumped       = bumped_q;

endmodule

// File: tb/tb_map_scroll_ctrl.sv
// tb/tb_map_scroll_ctrl.sv - self-checking bench for map_scroll_ctrl
module tb_map_scroll_ctrl;

  localparam int FRAME_CYC = 12;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       VGA_VS;
  logic [3:0] state_num;
  logic       charIsMoving;
  logic       charIsRunning;
  logic [1:0] direction;
  logic [5:0] tile_x, tile_y;
  logic [9:0] scroll_x, scroll_y;
  logic       walking, step_done, bumped;

  map_scroll_ctrl_if mif ();

  map_scroll_ctrl dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .VGA_VS        (VGA_VS),
    .state_num     (state_num),
    .charIsMoving  (charIsMoving),
    .charIsRunning (charIsRunning),
    .direction     (direction),
    .mif           (mif),
    .tile_x        (tile_x),
    .tile_y        (tile_y),
    .scroll_x      (scroll_x),
    .scroll_y      (scroll_y),
    .walking       (walking),
    .step_done     (step_done),
    .bumped        (bumped)
  );

  always #5 Clk = ~Clk;

  int  total = 0;
  int  bad   = 0;
  bit  solid [4096];

  // collision memory: valid one cycle after the strobe, junk otherwise
  always @(posedge Clk) begin
    if (mif.map_rd) mif.map_rdata <= solid[mif.map_addr];
    else            mif.map_rdata <= 1'($urandom);
  end

  // reference model: position in tiles, glide progress in pixels
  int m_x, m_y, m_off, m_dir, m_run;
  bit m_moving;
  int e_rd, e_bp, e_dn, e_addr;
  int n_rd, n_bp, n_dn, last_addr;
  int rd_cyc, wk_cyc, bp_cyc;

  function automatic int dxf(int d);
    return (d == 3) ? 1 : (d == 2) ? -1 : 0;
  endfunction

  function automatic int dyf(int d);
    return (d == 0) ? 1 : (d == 1) ? -1 : 0;
  endfunction

  function automatic int exp_sx();
    return m_x * 16 + dxf(m_dir) * m_off;
  endfunction

  function automatic int exp_sy();
    return m_y * 16 + dyf(m_dir) * m_off;
  endfunction

  task automatic model_step(input int sn, input bit mv, input bit rn, input int dr);
    int tx, ty;
    e_rd = 0; e_bp = 0; e_dn = 0;
    if (m_moving) begin
      if (sn != 3) begin
        m_moving = 0; m_off = 0;
      end else begin
        m_off += m_run ? 2 : 1;
        if (m_off >= 16) begin
          m_x += dxf(m_dir); m_y += dyf(m_dir);
          m_off = 0; m_moving = 0; e_dn = 1;
        end
      end
    end else if (sn == 3 && mv) begin
      m_dir = dr; m_run = rn;
      tx = m_x + dxf(dr); ty = m_y + dyf(dr);
      if (tx < 0 || tx > 63 || ty < 0 || ty > 63) begin
        e_bp = 1;
      end else begin
        e_rd = 1; e_addr = ty * 64 + tx;
        if (solid[e_addr]) e_bp = 1;
        else begin m_moving = 1; m_off = 0; end
      end
    end
  endtask

  task automatic apply_reset();
    Reset = 1'b0; VGA_VS = 1'b0; state_num = 4'd3;
    charIsMoving = 1'b0; charIsRunning = 1'b0; direction = 2'd0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    m_x = 10; m_y = 10; m_off = 0; m_dir = 0; m_run = 0; m_moving = 0;
    @(negedge Clk);
  endtask

  task automatic do_frame(input logic [3:0] sn, input bit mv, input bit rn, input logic [1:0] dr);
    state_num = sn; charIsMoving = mv; charIsRunning = rn; direction = dr;
    n_rd = 0; n_bp = 0; n_dn = 0; last_addr = -1;
    rd_cyc = -1; wk_cyc = -1; bp_cyc = -1;
    VGA_VS = 1'b1;
    for (int c = 0; c < FRAME_CYC; c++) begin
      @(negedge Clk);
      if (c == 5) VGA_VS = 1'b0;
      if (mif.map_rd) begin n_rd++; last_addr = int'(mif.map_addr); if (rd_cyc < 0) rd_cyc = c; end
      if (bumped) begin n_bp++; if (bp_cyc < 0) bp_cyc = c; end
      if (step_done) n_dn++;
      if (walking && rd_cyc >= 0 && wk_cyc < 0) wk_cyc = c;
    end
    model_step(int'(sn), mv, rn, int'(dr));
  endtask

  task automatic test_reset();
    apply_reset();
    total += 9;
    if (tile_x !== 6'd10) begin bad++; $display("FAIL reset_tile_x: got %0d want 10", tile_x); end
    if (tile_y !== 6'd10) begin bad++; $display("FAIL reset_tile_y: got %0d want 10", tile_y); end
    if (scroll_x !== 10'd160) begin bad++; $display("FAIL reset_scroll_x: got %0d want 160", scroll_x); end
    if (scroll_y !== 10'd160) begin bad++; $display("FAIL reset_scroll_y: got %0d want 160", scroll_y); end
    if (mif.map_rd !== 1'b0) begin bad++; $display("FAIL reset_map_rd: got %b want 0", mif.map_rd); end
    if (mif.map_addr !== 12'd0) begin bad++; $display("FAIL reset_map_addr: got %0d want 0", mif.map_addr); end
    if (step_done !== 1'b0) begin bad++; $display("FAIL reset_step_done: got %b want 0", step_done); end
    if (bumped !== 1'b0) begin bad++; $display("FAIL reset_bumped: got %b want 0", bumped); end
    if (walking !== 1'b0) begin bad++; $display("FAIL reset_walking: got %b want 0", walking); end
  endtask

  task automatic test_walk_right();
    int dn = 0;
    apply_reset();
    do_frame(4'd3, 1, 0, 2'd3);
    total += 4;
    if (last_addr != 651) begin bad++; $display("FAIL walk_addr: got %0d want 651", last_addr); end
    if (rd_cyc != 2) begin bad++; $display("FAIL walk_rd_latency: got %0d want 2", rd_cyc); end
    if (wk_cyc - rd_cyc != 2) begin bad++; $display("FAIL walk_move_latency: got %0d want 2", wk_cyc - rd_cyc); end
    if (walking !== 1'b1) begin bad++; $display("FAIL walk_walking: got %b want 1", walking); end
    for (int i = 1; i <= 16; i++) begin
      do_frame(4'd3, 1, 0, 2'd3);
      dn += n_dn;
      total++;
      if (int'(scroll_x) != 160 + i) begin bad++; $display("FAIL walk_scroll_x[%0d]: got %0d want %0d", i, scroll_x, 160 + i); end
    end
    total += 3;
    if (dn != 1) begin bad++; $display("FAIL walk_step_done_count: got %0d want 1", dn); end
    if (tile_x !== 6'd11) begin bad++; $display("FAIL walk_tile_x: got %0d want 11", tile_x); end
    if (walking !== 1'b0) begin bad++; $display("FAIL walk_idle_after: got %b want 0", walking); end
  endtask

  task automatic test_run_up();
    apply_reset();
    do_frame(4'd3, 1, 1, 2'd1);
    for (int i = 1; i <= 8; i++) begin
      do_frame(4'd3, 1, 1, 2'd1);
      total++;
      if (int'(scroll_y) != 160 - 2 * i) begin bad++; $display("FAIL run_scroll_y[%0d]: got %0d want %0d", i, scroll_y, 160 - 2 * i); end
    end
    total += 2;
    if (tile_y !== 6'd9) begin bad++; $display("FAIL run_tile_y: got %0d want 9", tile_y); end
    if (n_dn != 1) begin bad++; $display("FAIL run_step_done: got %0d want 1", n_dn); end
  endtask

  task automatic test_blocked();
    apply_reset();
    solid[651] = 1'b1;
    do_frame(4'd3, 1, 0, 2'd3);
    total += 6;
    if (n_rd != 1 || last_addr != 651) begin bad++; $display("FAIL blk_read: got %0d@%0d want 1@651", n_rd, last_addr); end
    if (n_bp != 1) begin bad++; $display("FAIL blk_bumped: got %0d want 1", n_bp); end
    if (bp_cyc - rd_cyc != 2) begin bad++; $display("FAIL blk_bump_latency: got %0d want 2", bp_cyc - rd_cyc); end
    if (wk_cyc != -1) begin bad++; $display("FAIL blk_walking: got cycle %0d want never", wk_cyc); end
    if (tile_x !== 6'd10) begin bad++; $display("FAIL blk_tile_x: got %0d want 10", tile_x); end
    if (scroll_x !== 10'd160) begin bad++; $display("FAIL blk_scroll_x: got %0d want 160", scroll_x); end
    solid[651] = 1'b0;
  endtask

  task automatic test_edge_bump();
    apply_reset();
    for (int i = 0; i < 90; i++) do_frame(4'd3, 1, 1, 2'd2);
    for (int i = 0; i < 90; i++) do_frame(4'd3, 1, 1, 2'd1);
    total += 2;
    if (tile_x !== 6'd0 || tile_y !== 6'd0) begin bad++; $display("FAIL edge_origin: got (%0d,%0d) want (0,0)", tile_x, tile_y); end
    if (scroll_x !== 10'd0 || scroll_y !== 10'd0) begin bad++; $display("FAIL edge_scroll: got (%0d,%0d) want (0,0)", scroll_x, scroll_y); end
    do_frame(4'd3, 1, 0, 2'd2);
    total += 3;
    if (n_bp != 1) begin bad++; $display("FAIL edge_left_bumped: got %0d want 1", n_bp); end
    if (n_rd != 0) begin bad++; $display("FAIL edge_left_no_read: got %0d want 0", n_rd); end
    if (tile_x !== 6'd0 || tile_y !== 6'd0) begin bad++; $display("FAIL edge_left_pos: got (%0d,%0d) want (0,0)", tile_x, tile_y); end
    do_frame(4'd3, 1, 0, 2'd1);
    total += 2;
    if (n_bp != 1) begin bad++; $display("FAIL edge_up_bumped: got %0d want 1", n_bp); end
    if (n_rd != 0) begin bad++; $display("FAIL edge_up_no_read: got %0d want 0", n_rd); end
  endtask

  task automatic test_abort();
    apply_reset();
    for (int i = 0; i < 6; i++) do_frame(4'd3, 1, 0, 2'd3);
    total++;
    if (scroll_x !== 10'd165) begin bad++; $display("FAIL abort_mid_scroll: got %0d want 165", scroll_x); end
    do_frame(4'd0, 1, 0, 2'd3);
    total += 4;
    if (scroll_x !== 10'd160) begin bad++; $display("FAIL abort_scroll_x: got %0d want 160", scroll_x); end
    if (tile_x !== 6'd10) begin bad++; $display("FAIL abort_tile_x: got %0d want 10", tile_x); end
    if (n_dn != 0) begin bad++; $display("FAIL abort_step_done: got %0d want 0", n_dn); end
    if (walking !== 1'b0) begin bad++; $display("FAIL abort_walking: got %b want 0", walking); end
  endtask

  task automatic test_dir_change_and_reset();
    int dn = 0;
    apply_reset();
    do_frame(4'd3, 1, 0, 2'd3);
    for (int i = 0; i < 16; i++) begin do_frame(4'd3, 1, 0, 2'd0); dn += n_dn; end
    total += 3;
    if (tile_x !== 6'd11 || tile_y !== 6'd10) begin bad++; $display("FAIL dirchg_pos: got (%0d,%0d) want (11,10)", tile_x, tile_y); end
    if (scroll_x !== 10'd176 || scroll_y !== 10'd160) begin bad++; $display("FAIL dirchg_scroll: got (%0d,%0d) want (176,160)", scroll_x, scroll_y); end
    if (dn != 1) begin bad++; $display("FAIL dirchg_done: got %0d want 1", dn); end
    apply_reset();
    for (int i = 0; i < 4; i++) do_frame(4'd3, 1, 0, 2'd3);
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    total += 3;
    if (scroll_x !== 10'd160) begin bad++; $display("FAIL rst_mid_scroll_x: got %0d want 160", scroll_x); end
    if (walking !== 1'b0) begin bad++; $display("FAIL rst_mid_walking: got %b want 0", walking); end
    if (tile_x !== 6'd10) begin bad++; $display("FAIL rst_mid_tile_x: got %0d want 10", tile_x); end
    apply_reset();
  endtask

  task automatic test_random();
    apply_reset();
    for (int a = 0; a < 4096; a++) solid[a] = ($urandom_range(4) == 0);
    for (int f = 0; f < 300; f++) begin
      logic [3:0] sn;
      sn = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : 4'd3;
      do_frame(sn, ($urandom_range(4) != 0), 1'($urandom), 2'($urandom));
      total += 8;
      if (int'(tile_x) != m_x) begin bad++; $display("FAIL rnd_tile_x[%0d]: got %0d want %0d", f, tile_x, m_x); end
      if (int'(tile_y) != m_y) begin bad++; $display("FAIL rnd_tile_y[%0d]: got %0d want %0d", f, tile_y, m_y); end
      if (int'(scroll_x) != exp_sx()) begin bad++; $display("FAIL rnd_scroll_x[%0d]: got %0d want %0d", f, scroll_x, exp_sx()); end
      if (int'(scroll_y) != exp_sy()) begin bad++; $display("FAIL rnd_scroll_y[%0d]: got %0d want %0d", f, scroll_y, exp_sy()); end
      if (walking !== m_moving) begin bad++; $display("FAIL rnd_walking[%0d]: got %b want %b", f, walking, m_moving); end
      if (n_rd != e_rd) begin bad++; $display("FAIL rnd_reads[%0d]: got %0d want %0d", f, n_rd, e_rd); end
      if (n_bp != e_bp) begin bad++; $display("FAIL rnd_bumped[%0d]: got %0d want %0d", f, n_bp, e_bp); end
      if (n_dn != e_dn) begin bad++; $display("FAIL rnd_step_done[%0d]: got %0d want %0d", f, n_dn, e_dn); end
      if (e_rd == 1) begin
        total++;
        if (last_addr != e_addr) begin bad++; $display("FAIL rnd_addr[%0d]: got %0d want %0d", f, last_addr, e_addr); end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) solid[a] = 1'b0;
    test_reset();
    test_walk_right();
    test_run_up();
    test_blocked();
    test_edge_bump();
    test_abort();
    test_dir_change_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
